mtm_alu_serializer: RTL and testbench

MTM_ALU_SERIALIZER -- requirements
Module: mtm_Alu_serializer

---
 rtl/mtm_alu_serializer_pkg.sv | 16 +
 rtl/mtm_alu_serializer_bit_timer.sv | 27 ++
 rtl/mtm_alu_serializer.sv | 86 ++++++++
 tb/tb_mtm_alu_serializer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mtm_alu_serializer_pkg.sv
// Shared constants and state encoding for the MTM ALU serial link.
// Used by the serializer and the upstream deserializer.
package mtm_Alu_pkg;

    localparam int FRAME_W = 11;
    localparam int FRAMES  = 5;
    localparam int RESP_W  = FRAME_W * FRAMES;
    localparam int ERR_BIT = 9;
    localparam int CNT_W   = $clog2(RESP_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/mtm_alu_serializer_bit_timer.sv
// Bit-period divider: counts 0..CLK_PER_BIT-1 while enabled.
// tick marks the last cycle of each bit; the count then wraps to 0.
module mtm_Alu_bit_timer #(
    parameter int unsigned CLK_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(CLK_PER_BIT - 1);

    logic [15:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!en || tick)
            cnt <= '0;
        else
            cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/mtm_alu_serializer.sv
// Shifts five 11-bit ALU response frames out on sout, MSB first.
// Optional MTM_ALU_SHORT_ERR_EN: error responses send only the last frame.
module mtm_alu_serializer
    import mtm_Alu_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RESP_W-1:0] ALU_out,
    input  logic              data_ready,
    output logic              sout,
    output logic              busy,
    output logic              drop
);

    state_t            state, state_nxt;
    logic [RESP_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic              drop_nxt;
    logic              tick;
    logic              last;
    logic              accept;

    mtm_Alu_bit_timer #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (state == SEND),
        .tick(tick)
    );

    // A strobe in the final bit cycle is taken so responses run gapless.
    assign last   = tick && (bit_cnt == CNT_W'(1));
    assign accept = data_ready && ((state == IDLE) || last);

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        drop_nxt    = 1'b0;
        unique case (state)
            IDLE: ;
            SEND: begin
                if (tick) begin
                    shreg_nxt   = {shreg[RESP_W-2:0], 1'b0};
                    bit_cnt_nxt = bit_cnt - CNT_W'(1);
                end
                if (last)
                    state_nxt = IDLE;
                drop_nxt = data_ready && !last;
            end
        endcase
        if (accept) begin
            state_nxt   = SEND;
            shreg_nxt   = ALU_out;
            bit_cnt_nxt = CNT_W'(RESP_W);
`ifdef MTM_ALU_SHORT_ERR_EN
            if (ALU_out[ERR_BIT]) begin
                shreg_nxt   = {ALU_out[FRAME_W-1:0],
                               {(RESP_W-FRAME_W){1'b0}}};
                bit_cnt_nxt = CNT_W'(FRAME_W);
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            drop    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            drop    <= drop_nxt;
        end
    end

    assign busy = (state == SEND);
    assign sout = (state == SEND) ? shreg[RESP_W-1] : 1'b1;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Randomized bench for mtm_alu_serializer against a queue-based line model.
// Honors MTM_ALU_SHORT_ERR_EN the same way as the design build.
module tb_mtm_alu_serializer;

    localparam int unsigned CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [54:0] alu_out = '0;
    logic        data_ready = 1'b0;
    logic        sout, busy, drop;

    int n_chk  = 0;
    int n_pass = 0;

    // expected sout value for every future SEND cycle
    logic exp_q[$];
    logic exp_drop = 1'b0;

    mtm_alu_serializer #(
        .CLK_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ALU_out   (alu_out),
        .data_ready(data_ready),
        .sout      (sout),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    endtask

    function automatic logic [54:0] make_resp();
        logic [54:0] r;
        r = '0;
        for (int f = 0; f < 5; f++)
            r[f*11 +: 11] = {1'b0, 1'($urandom_range(0, 1)),
                             8'($urandom), 1'b1};
        return r;
    endfunction

    function automatic int resp_len(input logic [54:0] r);
        int n;
        n = 55;
`ifdef MTM_ALU_SHORT_ERR_EN
        if (r[9])
            n = 11;
`endif
        return n;
    endfunction

    task automatic push_resp(input logic [54:0] v);
        int n;
        n = resp_len(v);
        for (int i = 0; i < n; i++)
            repeat (CPB)
                exp_q.push_back(n == 55 ? v[54-i] : v[10-i]);
    endtask

    // one clock: check current outputs, then present inputs for next edge
    task automatic step(input logic dr, input logic [54:0] v);
        logic idle_exp;
        @(negedge clk);
        idle_exp = (exp_q.size() == 0);
        chk("sout", sout, idle_exp ? 1'b1 : exp_q[0]);
        chk("busy", busy, !idle_exp);
        chk("drop", drop, exp_drop);
        if (!idle_exp)
            void'(exp_q.pop_front());
        data_ready = dr;
        alu_out    = v;
        exp_drop   = dr && (exp_q.size() != 0);
        if (dr && exp_q.size() == 0)
            push_resp(v);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++)
            step(1'b0, '0);
        repeat (3) step(1'b0, '0);
    endtask

    initial begin
        logic [54:0] r, r2;
        int len, dcy;

        repeat (2) @(negedge clk);
        chk("rst_sout", sout, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", drop, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;

        // directed response, strobed on first edge after reset release
        step(1'b1, {11'h003, 11'h005, 11'h009, 11'h011, 11'h183});
        drain();

        // random responses with an overlapping strobe mid-transfer
        for (int t = 0; t < 8; t++) begin
            r   = make_resp();
            r2  = make_resp();
            len = resp_len(r) * CPB;
            dcy = $urandom_range(1, len - 2);
            step(1'b1, r);
            for (int k = 1; k < len + 3; k++)
                step(k == dcy, k == dcy ? r2 : '0);
            drain();
        end

        // back-to-back: strobe during the last bit cycle
        r  = make_resp();
        r2 = make_resp();
        step(1'b1, r);
        for (int k = 0; k < 300 && exp_q.size() != 1; k++)
            step(1'b0, '0);
        step(1'b1, r2);
        drain();

        // asynchronous reset around bit 20
        r = make_resp();
        r[9] = 1'b0;
        step(1'b1, r);
        repeat (20 * CPB) step(1'b0, '0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_sout", sout, 1'b1);
        chk("arst_busy", busy, 1'b0);
        exp_q.delete();
        exp_drop = 1'b0;
        @(negedge clk);
        chk("arst_drop", drop, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        step(1'b1, make_resp());
        drain();

        // error-flagged response
        r = make_resp();
        r[10:0] = 11'b01_1100_1001_1;
        step(1'b1, r);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
